// File: rtl/seq_generator_pkg.sv
// Shared constants, state encoding and flip-mask helper
// for the serial pattern transmitter.
package seq_generator_pkg;

    localparam int PAT_LEN = 8;
    localparam logic [PAT_LEN-1:0] PATTERN = 8'b10011011;
    localparam logic IDLE_BIT = 1'b0;
    localparam int IDX_W = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(PAT_LEN - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    // Index 0 is the first bit on the line, i.e. the MSB of the frame.
    function automatic logic [PAT_LEN-1:0] flip_mask(
        input logic en,
        input logic [IDX_W-1:0] idx
    );
        logic [PAT_LEN-1:0] m;
        m = '0;
        if (en) m[LAST_IDX - idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/seq_serializer.sv
// Frame shift register with bit counter; its MSB flop is
// the registered serial output.
module seq_serializer
    import seq_generator_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic             flip_en,
    input  logic [IDX_W-1:0] flip_idx,
    output logic             outp,
    output logic [IDX_W-1:0] bit_idx
);

    logic [PAT_LEN-1:0] shreg;

    // Shifting in IDLE_BIT leaves the line idle once the last bit is gone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg   <= {PAT_LEN{IDLE_BIT}};
            bit_idx <= '0;
        end else if (clear) begin
            shreg   <= {PAT_LEN{IDLE_BIT}};
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= PATTERN ^ flip_mask(flip_en, flip_idx);
            bit_idx <= '0;
        end else if (shift) begin
            shreg   <= {shreg[PAT_LEN-2:0], IDLE_BIT};
            bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    assign outp = shreg[PAT_LEN-1];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: bursts of fixed frames with
// programmable repeat count, inter-frame gap and bit flip.
module seq_generator
    import seq_generator_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rep_cnt,
    input  logic [3:0] gap_len,
    input  logic       flip_en,
    input  logic [2:0] flip_idx,
    input  logic       abort,
    output logic       outp,
    output logic       busy,
    output logic       frame_end,
    output logic       done,
    output logic [7:0] frames_sent
);

    state_t state, state_d;
    logic [3:0] reps_left, reps_d;
    logic [3:0] gap_cnt, gap_d;
    logic [3:0] gap_len_q;
    logic       flip_en_q;
    logic [2:0] flip_idx_q;
    logic       busy_d, fe_d, done_d, cnt_inc;
    logic       latch, load, shift, clear;
    logic       ser_flip_en;
    logic [2:0] ser_flip_idx;
    logic [2:0] bit_idx;

    seq_serializer u_ser (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .clear    (clear),
        .flip_en  (ser_flip_en),
        .flip_idx (ser_flip_idx),
        .outp     (outp),
        .bit_idx  (bit_idx)
    );

    // Outputs are computed for the state being entered and registered.
    always_comb begin
        state_d      = state;
        reps_d       = reps_left;
        gap_d        = gap_cnt;
        busy_d       = 1'b0;
        fe_d         = 1'b0;
        done_d       = 1'b0;
        cnt_inc      = 1'b0;
        latch        = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        clear        = 1'b0;
        ser_flip_en  = flip_en_q;
        ser_flip_idx = flip_idx_q;
        if (abort) begin
            state_d = ST_IDLE;
            clear   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ser_flip_en  = flip_en;
                    ser_flip_idx = flip_idx;
                    if (start) begin
                        latch  = 1'b1;
                        reps_d = rep_cnt;
                        if (rep_cnt != 4'd0) begin
                            state_d = ST_SEND;
                            load    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    busy_d = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        reps_d = reps_left - 4'd1;
                        if (reps_left == 4'd1) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            shift   = 1'b1;
                        end else if (gap_len_q == 4'd0) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = gap_len_q;
                            shift   = 1'b1;
                        end
                    end else begin
                        shift = 1'b1;
                        if (bit_idx == PENULT_IDX) begin
                            fe_d    = 1'b1;
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    busy_d = 1'b1;
                    gap_d  = gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        state_d = ST_SEND;
                        load    = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            reps_left   <= '0;
            gap_cnt     <= '0;
            gap_len_q   <= '0;
            flip_en_q   <= 1'b0;
            flip_idx_q  <= '0;
            busy        <= 1'b0;
            frame_end   <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            state     <= state_d;
            reps_left <= reps_d;
            gap_cnt   <= gap_d;
            busy      <= busy_d;
            frame_end <= fe_d;
            done      <= done_d;
            if (cnt_inc) frames_sent <= frames_sent + 8'd1;
            if (latch) begin
                gap_len_q  <= gap_len;
                flip_en_q  <= flip_en;
                flip_idx_q <= flip_idx;
            end
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: per-cycle comparison
// against a frame-level model of each burst.
module tb_seq_generator;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] rep_cnt;
    logic [3:0] gap_len;
    logic       flip_en;
    logic [2:0] flip_idx;
    logic       abort;
    logic       outp;
    logic       busy;
    logic       frame_end;
    logic       done;
    logic [7:0] frames_sent;

    int checks = 0;
    int errors = 0;
    logic [7:0] fs_model = 8'd0;

    seq_generator dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rep_cnt     (rep_cnt),
        .gap_len     (gap_len),
        .flip_en     (flip_en),
        .flip_idx    (flip_idx),
        .abort       (abort),
        .outp        (outp),
        .busy        (busy),
        .frame_end   (frame_end),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clock = ~clock;

    // Cycle 1 is the cycle after the edge that samples start.
    // Expected entry per cycle: {outp, busy, frame_end, done}.
    task automatic run_burst(input string tag, input int rep, input int gap,
                             input bit fl, input int idx,
                             input int abort_at, input int mid_at);
        logic [3:0] eq[$];
        logic [7:0] pat;
        logic [3:0] got;
        pat = 8'b10011011;
        for (int r = 0; r < rep; r++) begin
            for (int i = 0; i < 8; i++)
                eq.push_back({pat[7-i] ^ (fl && i == idx), 1'b1,
                              i == 7, 1'b0});
            if (r < rep - 1)
                for (int g = 0; g < gap; g++) eq.push_back(4'b0100);
        end
        eq.push_back(4'b0001);
        eq.push_back(4'b0000);
        eq.push_back(4'b0000);
        if (abort_at > 0)
            for (int c = abort_at; c < eq.size(); c++) eq[c] = 4'b0000;
        @(negedge clock);
        start    = 1'b1;
        rep_cnt  = 4'(rep);
        gap_len  = 4'(gap);
        flip_en  = fl;
        flip_idx = 3'(idx);
        for (int c = 1; c <= eq.size(); c++) begin
            @(negedge clock);
            rep_cnt  = 4'($urandom);
            gap_len  = 4'($urandom);
            flip_en  = 1'($urandom);
            flip_idx = 3'($urandom);
            if (eq[c-1][1]) fs_model = fs_model + 8'd1;
            got = {outp, busy, frame_end, done};
            checks++;
            if (got !== eq[c-1]) begin
                errors++;
                $display("FAIL %s bits cycle %0d got %b exp %b",
                         tag, c, got, eq[c-1]);
            end
            checks++;
            if (frames_sent !== fs_model) begin
                errors++;
                $display("FAIL %s frames_sent cycle %0d got %0d exp %0d",
                         tag, c, frames_sent, fs_model);
            end
            start = (c == mid_at);
            abort = (abort_at > 0 && c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rep_cnt = 4'd0;
        gap_len = 4'd0;
        flip_en = 1'b0;
        flip_idx = 3'd0;
        repeat (3) @(negedge clock);
        checks++;
        if ({outp, busy, frame_end, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_bits got %b exp 0000",
                     {outp, busy, frame_end, done});
        end
        checks++;
        if (frames_sent !== 8'd0) begin
            errors++;
            $display("FAIL reset_frames got %0d exp 0", frames_sent);
        end
        reset = 1'b1;
        fs_model = 8'd0;
        @(negedge clock);
    endtask

    task automatic test_single();
        run_burst("single", 1, 0, 1'b0, 0, 0, 0);
        checks++;
        if (frames_sent !== 8'd1) begin
            errors++;
            $display("FAIL single_count got %0d exp 1", frames_sent);
        end
    endtask

    task automatic test_back_to_back();
        run_burst("b2b", 2, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_gap();
        run_burst("gap", 2, 3, 1'b0, 0, 0, 0);
        checks++;
        if (frames_sent !== 8'd5) begin
            errors++;
            $display("FAIL gap_count got %0d exp 5", frames_sent);
        end
    endtask

    task automatic test_flip();
        run_burst("flip", 1, 0, 1'b1, 2, 0, 0);
    endtask

    task automatic test_abort();
        run_burst("abort", 3, 0, 1'b0, 0, 4, 0);
        checks++;
        if (frames_sent !== 8'd6) begin
            errors++;
            $display("FAIL abort_count got %0d exp 6", frames_sent);
        end
    endtask

    task automatic test_zero_rep();
        run_burst("zero_rep", 0, 2, 1'b0, 0, 0, 0);
    endtask

    task automatic test_ignore_start();
        run_burst("ignore_start", 2, 1, 1'b1, 7, 0, 5);
        run_burst("start_in_done", 1, 0, 1'b0, 0, 0, 9);
    endtask

    task automatic test_start_abort_idle();
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        rep_cnt = 4'd3;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            start = 1'b0;
            abort = 1'b0;
            checks++;
            if ({outp, busy, frame_end, done} !== 4'b0000) begin
                errors++;
                $display("FAIL start_abort cycle %0d got %b exp 0000",
                         c, {outp, busy, frame_end, done});
            end
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clock);
        start = 1'b1;
        rep_cnt = 4'd3;
        gap_len = 4'd0;
        flip_en = 1'b0;
        repeat (4) begin
            @(negedge clock);
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got %b exp 1", busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({outp, busy, frame_end, done, frames_sent} !== 12'd0) begin
            errors++;
            $display("FAIL midframe_reset got %b exp all zero",
                     {outp, busy, frame_end, done, frames_sent});
        end
        fs_model = 8'd0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        int rep, gap, idx, ab, mid, len;
        bit fl;
        for (int n = 0; n < 40; n++) begin
            rep = $urandom_range(0, 4);
            gap = $urandom_range(0, 5);
            fl  = 1'($urandom);
            idx = $urandom_range(0, 7);
            len = (rep == 0) ? 1 : rep * 8 + (rep - 1) * gap + 1;
            ab  = 0;
            mid = 0;
            if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, len);
            else if ($urandom_range(0, 1) == 1) mid = $urandom_range(1, len);
            run_burst("random", rep, gap, fl, idx, ab, mid);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] base;
        base = frames_sent;
        for (int n = 0; n < 18; n++)
            run_burst("wrap", 15, 0, 1'b0, 0, 0, 0);
        checks++;
        if (frames_sent !== base + 8'd14) begin
            errors++;
            $display("FAIL wrap_count got %0d exp %0d",
                     frames_sent, base + 8'd14);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_flip();
        test_abort();
        test_zero_rep();
        test_ignore_start();
        test_start_abort_idle();
        test_reset_midframe();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
